// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the alignment/legality check for the
// load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_MERGE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads, so they fault as stores.
  function automatic logic isMisaligned(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       write);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// master = pipeline + memory side, slave = the load/store unit.
interface load_store_unit_if #(parameter int DATA_W = 32);
  logic              reqValid;
  logic              reqWrite;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic              stall;
  logic              respValid;
  logic [DATA_W-1:0] respData;
  logic              misaligned;
  logic              memRead;
  logic              memWrite;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;

  modport master (
    output reqValid, reqWrite, funct3, reqAddr, reqData, memReadData,
    input  stall, respValid, respData, misaligned,
           memRead, memWrite, memAddr, memWriteData
  );

  modport slave (
    input  reqValid, reqWrite, funct3, reqAddr, reqData, memReadData,
    output stall, respValid, respData, misaligned,
           memRead, memWrite, memAddr, memWriteData
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: sub-word extract/extend for loads and
// byte/half merge into a read word for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic        half_i,
  input  logic [15:0] data_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset_i)
      2'd0:    byte_lane = word_i[7:0];
      2'd1:    byte_lane = word_i[15:8];
      2'd2:    byte_lane = word_i[23:16];
      default: byte_lane = word_i[31:24];
    endcase
    half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_o = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_o = {24'd0, byte_lane};
      F3_HU:   load_o = {16'd0, half_lane};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    if (half_i) begin
      if (offset_i[1]) merge_o[31:16] = data_i;
      else             merge_o[15:0]  = data_i;
    end else begin
      case (offset_i)
        2'd0:    merge_o[7:0]   = data_i[7:0];
        2'd1:    merge_o[15:8]  = data_i[7:0];
        2'd2:    merge_o[23:16] = data_i[7:0];
        default: merge_o[31:24] = data_i[7:0];
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: single-cycle sw, two-cycle loads and
// read-modify-write sub-word stores on a word-only data memory.
//
// state     | meaning
// IDLE      | accepting requests; sw and faults complete here
// LOAD_RESP | read data arriving; extend and register the response
// RMW_MERGE | read word arriving; write back with the sub-word replaced
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  lsu_state_e        state_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [15:0]       data_q;
  logic [DATA_W-3:0] word_addr_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_valid_q;
  logic              misaligned_q;

  logic        accept;
  logic        fault;
  logic        is_sw;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && bus.reqValid && !rst;
  assign fault  = isMisaligned(bus.funct3, bus.reqAddr[1:0], bus.reqWrite);
  assign is_sw  = bus.reqWrite && (bus.funct3 == F3_W);

  lsu_lane_align u_lane_align (
    .word_i   (bus.memReadData),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .half_i   (f3_q[0]),
    .data_i   (data_q),
    .load_o   (load_ext),
    .merge_o  (merged)
  );

  // RMW write-back uses the latched address; the request bus may carry junk.
  always_comb begin
    bus.memRead      = 1'b0;
    bus.memWrite     = 1'b0;
    bus.memAddr      = {bus.reqAddr[DATA_W-1:2], 2'b00};
    bus.memWriteData = bus.reqData;
    if (state_q == RMW_MERGE && !rst) begin
      bus.memWrite     = 1'b1;
      bus.memAddr      = {word_addr_q, 2'b00};
      bus.memWriteData = merged;
    end else if (accept && !fault) begin
      bus.memWrite = is_sw;
      bus.memRead  = !is_sw;
    end
  end

  assign bus.stall      = (state_q != IDLE);
  assign bus.respValid  = resp_valid_q;
  assign bus.respData   = resp_data_q;
  assign bus.misaligned = misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= 2'd0;
      f3_q         <= 3'd0;
      data_q       <= 16'd0;
      word_addr_q  <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.reqValid) begin
            if (fault) begin
              misaligned_q <= 1'b1;
            end else if (!is_sw) begin
              off_q       <= bus.reqAddr[1:0];
              f3_q        <= bus.funct3;
              data_q      <= bus.reqData[15:0];
              word_addr_q <= bus.reqAddr[DATA_W-1:2];
              state_q     <= bus.reqWrite ? RMW_MERGE : LOAD_RESP;
            end
          end
        end
        LOAD_RESP: begin
          resp_data_q  <= load_ext;
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a word memory
// model and a byte-level reference of memory contents and load results.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  load_store_unit_if #(.DATA_W(32)) bus ();

  load_store_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (bus.memWrite) mem[bus.memAddr[11:2]] <= bus.memWriteData;
    if (bus.memRead) bus.memReadData <= mem[bus.memAddr[11:2]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bd_we   = 1'b1;
    bd_idx  = a[11:2];
    bd_data = d;
    ref_mem[a[11:2]] = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    bus.reqWrite = w;
    bus.funct3   = f3;
    bus.reqAddr  = a;
    bus.reqData  = d;
    bus.reqValid = 1'b1;
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = ref_mem[a[11:2]] >> (32'(a[1:0]) * 8);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b001: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = v & 32'hFF;
      3'b101: v = v & 32'hFFFF;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] d, input logic [31:0] word);
    int nbytes;
    logic [31:0] w;
    nbytes = (f3 == 3'b000) ? 1 : ((f3 == 3'b001) ? 2 : 4);
    w = word;
    for (int k = 0; k < nbytes; k++) w[(int'(lo) + k) * 8 +: 8] = d[k * 8 +: 8];
    return w;
  endfunction

  function automatic bit ref_fault(input bit w, input logic [2:0] f3, input logic [1:0] lo);
    bit legal;
    int size;
    legal = w ? (f3 inside {3'b000, 3'b001, 3'b010})
              : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    size  = 1 << f3[1:0];
    return !legal || ((int'(lo) % size) != 0);
  endfunction

  task automatic test_reset();
    drive(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678);
    tick();
    vectors++;
    if ({bus.memRead, bus.memWrite, bus.stall, bus.respValid, bus.misaligned} !== 5'b0 ||
        bus.respData !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: rd=%b wr=%b stall=%b rv=%b mis=%b data=%h, want all 0",
               bus.memRead, bus.memWrite, bus.stall, bus.respValid, bus.misaligned, bus.respData);
    end
    bus.reqValid = 1'b0;
    rst = 1'b0;
    tick();
    vectors++;
    if ({bus.memRead, bus.memWrite, bus.stall} !== 3'b0) begin
      miscompares++;
      $display("FAIL idle_strobes: rd=%b wr=%b stall=%b, want 0 0 0",
               bus.memRead, bus.memWrite, bus.stall);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  dir_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] dir_a   [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] dir_exp [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h00008899};
    logic [2:0]  ops     [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [31:0] a, exp;
    preload(32'h100, 32'h8899AABB);
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        f3 = dir_f3[i]; a = dir_a[i]; exp = dir_exp[i];
      end else begin
        f3 = ops[$urandom_range(0, 4)];
        a  = {20'd0, 4'b0011, 6'($urandom_range(0, 63)), 2'b00};
        if (f3[1:0] == 2'b00)      a[1:0] = 2'($urandom_range(0, 3));
        else if (f3[1:0] == 2'b01) a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
        preload(a, $urandom);
        exp = ref_load(f3, a);
      end
      drive(1'b0, f3, a, $urandom);
      vectors++;
      if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.memAddr !== {a[31:2], 2'b00}) begin
        miscompares++;
        $display("FAIL load_issue[%0d]: rd=%b wr=%b addr=%h, want rd=1 wr=0 addr=%h",
                 i, bus.memRead, bus.memWrite, bus.memAddr, {a[31:2], 2'b00});
      end
      tick();
      drive(1'b1, 3'b010, 32'h3F0, $urandom);
      vectors++;
      if (bus.stall !== 1'b1 || bus.respValid !== 1'b0 || bus.memWrite !== 1'b0 || bus.memRead !== 1'b0) begin
        miscompares++;
        $display("FAIL load_stall[%0d]: stall=%b rv=%b wr=%b rd=%b, want 1 0 0 0",
                 i, bus.stall, bus.respValid, bus.memWrite, bus.memRead);
      end
      tick();
      bus.reqValid = 1'b0;
      #1;
      vectors++;
      if (bus.respValid !== 1'b1 || bus.respData !== exp || bus.stall !== 1'b0) begin
        miscompares++;
        $display("FAIL load_resp[%0d]: rv=%b data=%h stall=%b, want rv=1 data=%h stall=0",
                 i, bus.respValid, bus.respData, bus.stall, exp);
      end
    end
  endtask

  task automatic test_rmw();
    logic [2:0]  f3;
    logic [31:0] a, d, exp;
    preload(32'h100, 32'h11223344);
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        f3 = 3'b000; a = 32'h101; d = 32'h5A;
      end else if (i == 1) begin
        f3 = 3'b001; a = 32'h102; d = 32'hBEEF;
      end else begin
        f3 = 3'($urandom_range(0, 1));
        a  = {20'd0, 4'b0011, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        if (f3 == 3'b001) a[0] = 1'b0;
        d  = $urandom;
        preload(a, $urandom);
      end
      exp = ref_store(f3, a[1:0], d, ref_mem[a[11:2]]);
      if (i == 0) exp = 32'h11225A44;
      if (i == 1) exp = 32'hBEEF5A44;
      ref_mem[a[11:2]] = exp;
      drive(1'b1, f3, a, d);
      vectors++;
      if (bus.memRead !== 1'b1 || bus.memWrite !== 1'b0 || bus.stall !== 1'b0) begin
        miscompares++;
        $display("FAIL rmw_read[%0d]: rd=%b wr=%b stall=%b, want 1 0 0",
                 i, bus.memRead, bus.memWrite, bus.stall);
      end
      tick();
      drive(1'b0, 3'b010, 32'h3F4, 32'h0);
      vectors++;
      if (bus.stall !== 1'b1 || bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 ||
          bus.memAddr !== {a[31:2], 2'b00}) begin
        miscompares++;
        $display("FAIL rmw_write[%0d]: stall=%b wr=%b rd=%b addr=%h, want 1 1 0 addr=%h",
                 i, bus.stall, bus.memWrite, bus.memRead, bus.memAddr, {a[31:2], 2'b00});
      end
      tick();
      bus.reqValid = 1'b0;
      #1;
      vectors++;
      if (bus.stall !== 1'b0 || bus.memWrite !== 1'b0 || mem[a[11:2]] !== exp) begin
        miscompares++;
        $display("FAIL rmw_result[%0d]: stall=%b wr=%b mem=%h, want 0 0 mem=%h",
                 i, bus.stall, bus.memWrite, mem[a[11:2]], exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b010, 32'(i * 4), d[i]);
      ref_mem[i] = d[i];
      vectors++;
      if (bus.memWrite !== 1'b1 || bus.memRead !== 1'b0 || bus.stall !== 1'b0 ||
          bus.memWriteData !== d[i] || bus.memAddr !== 32'(i * 4)) begin
        miscompares++;
        $display("FAIL sw_b2b[%0d]: wr=%b rd=%b stall=%b wdata=%h addr=%h, want 1 0 0 %h %h",
                 i, bus.memWrite, bus.memRead, bus.stall, bus.memWriteData, bus.memAddr,
                 d[i], 32'(i * 4));
      end
      tick();
    end
    bus.reqValid = 1'b0;
    #1;
    vectors++;
    if (bus.memWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_b2b_end: wr=%b, want 0", bus.memWrite);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b010, 32'(i * 4), 32'h0);
      tick();
      bus.reqValid = 1'b0;
      tick();
      vectors++;
      if (bus.respValid !== 1'b1 || bus.respData !== d[i]) begin
        miscompares++;
        $display("FAIL sw_readback[%0d]: rv=%b data=%h, want rv=1 data=%h",
                 i, bus.respValid, bus.respData, d[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic [2:0]  dir_f3 [3] = '{3'b010, 3'b001, 3'b011};
    logic        dir_w  [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] dir_a  [3] = '{32'h102, 32'h001, 32'h100};
    logic [2:0]  f3;
    logic        w;
    logic [31:0] a, d;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) begin
        f3 = dir_f3[i]; w = dir_w[i]; a = dir_a[i];
      end else begin
        for (int t = 0; t < 100; t++) begin
          f3 = 3'($urandom_range(0, 7));
          w  = 1'($urandom_range(0, 1));
          a  = {20'd0, 4'b0011, 6'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
          if (ref_fault(w, f3, a[1:0])) break;
        end
      end
      preload(a, $urandom);
      drive(w, f3, a, $urandom);
      vectors++;
      if (bus.memRead !== 1'b0 || bus.memWrite !== 1'b0) begin
        miscompares++;
        $display("FAIL fault_strobe[%0d]: rd=%b wr=%b, want 0 0", i, bus.memRead, bus.memWrite);
      end
      tick();
      d = $urandom;
      drive(1'b1, 3'b010, 32'h3C0, d);
      ref_mem[32'h3C0 >> 2] = d;
      vectors++;
      if (bus.misaligned !== 1'b1 || bus.stall !== 1'b0 || bus.memWrite !== 1'b1) begin
        miscompares++;
        $display("FAIL fault_pulse[%0d]: mis=%b stall=%b next_wr=%b, want 1 0 1",
                 i, bus.misaligned, bus.stall, bus.memWrite);
      end
      tick();
      bus.reqValid = 1'b0;
      #1;
      vectors++;
      if (bus.misaligned !== 1'b0 || mem[a[11:2]] !== ref_mem[a[11:2]] ||
          mem[32'h3C0 >> 2] !== d) begin
        miscompares++;
        $display("FAIL fault_after[%0d]: mis=%b mem=%h next=%h, want 0 %h %h",
                 i, bus.misaligned, mem[a[11:2]], mem[32'h3C0 >> 2], ref_mem[a[11:2]], d);
      end
    end
  endtask

  task automatic test_reset_in_rmw();
    logic [31:0] w;
    w = $urandom;
    preload(32'h200, w);
    drive(1'b1, 3'b000, 32'h200, 32'hFF);
    tick();
    bus.reqValid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.memRead, bus.memWrite, bus.stall, bus.respValid, bus.misaligned} !== 5'b0 ||
        bus.respData !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_rmw_outputs: rd=%b wr=%b stall=%b rv=%b mis=%b data=%h, want all 0",
               bus.memRead, bus.memWrite, bus.stall, bus.respValid, bus.misaligned, bus.respData);
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (mem[32'h200 >> 2] !== w) begin
      miscompares++;
      $display("FAIL rst_rmw_mem: mem=%h, want %h", mem[32'h200 >> 2], w);
    end
    drive(1'b0, 3'b010, 32'h200, 32'h0);
    vectors++;
    if (bus.memRead !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rmw_accept: rd=%b, want 1", bus.memRead);
    end
    tick();
    bus.reqValid = 1'b0;
    tick();
    vectors++;
    if (bus.respValid !== 1'b1 || bus.respData !== w) begin
      miscompares++;
      $display("FAIL rst_rmw_load: rv=%b data=%h, want rv=1 data=%h", bus.respValid, bus.respData, w);
    end
  endtask

  task automatic test_store_then_load();
    drive(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    tick();
    drive(1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    bus.reqValid = 1'b0;
    tick();
    vectors++;
    if (bus.respValid !== 1'b1 || bus.respData !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL sw_then_lw: rv=%b data=%h, want rv=1 data=cafef00d", bus.respValid, bus.respData);
    end
  endtask

  initial begin
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.funct3   = 3'b000;
    bus.reqAddr  = '0;
    bus.reqData  = '0;
    tick();
    test_reset();
    test_loads();
    test_rmw();
    test_back_to_back();
    test_faults();
    test_reset_in_rmw();
    test_store_then_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit placed between the EX/MEM pipeline register and the word-only data memory. It accepts one load or store per request. Sub-word stores (sb/sh) are done as a read-modify-write (RMW) on the word memory. Sub-word loads are extracted and sign- or zero-extended. The unit stalls the pipeline while a multi-cycle access is in flight and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- `DATA_W`, default 32: data and address width. Only 32 is supported.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock shared with data memory
- `rst`  in  1  asynchronous, active-high reset
- `reqValid`  in  1  request present this cycle
- `reqWrite`  in  1  1 = store, 0 = load
- `funct3`  in  3  loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores: 000 sb, 001 sh, 010 sw
- `reqAddr`  in  32  byte address
- `reqData`  in  32  store data, right-aligned
- `stall`  out  1  hold pipeline; the request is not accepted while high
- `respValid`  out  1  one-cycle pulse; `respData` is valid
- `respData`  out  32  extended load result, held until the next load response
- `misaligned`  out  1  one-cycle pulse reporting a faulted request
- `memRead`, `memWrite`  out  1  data-memory strobes
- `memAddr`  out  32  word-aligned address, `{addr[31:2],2'b00}`
- `memWriteData`  out  32  full word to write
- `memReadData`  in  32  memory read data, registered one cycle after `memRead`

## Operation
States: `IDLE`, `LOAD_RESP`, `RMW_MERGE`. `stall = (state != IDLE)`.

Acceptance:
- A request is accepted in `IDLE` when `reqValid` is high.
- In states other than `IDLE`, request inputs are ignored.

Fault check at acceptance:
- A request faults if it is lh/lhu/sh with `addr[0]=1`, lw/sw with `addr[1:0]!=0`, or has an unlisted `funct3`.
- On a fault: no strobe is asserted, `misaligned` pulses in the next cycle, and the state stays `IDLE`.

sw:
- `memWrite=1`, `memWriteData=reqData` in the acceptance cycle, driven combinationally from the inputs.
- No stall; the state stays `IDLE`.

Load (lb/lh/lw/lbu/lhu):
- `memRead=1` in the acceptance cycle.
- Latch byte offset and `funct3`, then go to `LOAD_RESP`.
- In `LOAD_RESP`: select the lane from `memReadData` by offset (byte lane = `offset*8`, half lane = `offset[1]*16`), extend per `funct3`, register the result into `respData`, pulse `respValid`, and return to `IDLE`.

sb/sh:
- `memRead=1` in the acceptance cycle.
- Latch offset, size and `reqData[15:0]`, then go to `RMW_MERGE`.
- In `RMW_MERGE`: drive `memWrite=1` and `memWriteData` = `memReadData` with only the addressed byte/half replaced, then return to `IDLE`.

General rules:
- `memRead` and `memWrite` are never high together.
- All strobes are 0 when idle with no valid request.

Reset (any state): state goes to `IDLE`. `respData`=0, `respValid`=0, `misaligned`=0, all strobes=0. A pending RMW is abandoned with no write. Reset dominates `reqValid`.

## Timing
- Acceptance cycle N: strobes and `memAddr` are combinational from the inputs (IDLE only).
- Load: `stall` high in N+1; `respValid` and `respData` valid in N+2; a new request can be accepted in N+2. Load-to-use latency is 2 cycles.
- sb/sh: `stall` high in N+1; the merged word is written at the N+1→N+2 edge; the next request is accepted in N+2.
- sw: single cycle. Back-to-back sw accesses are accepted every cycle.
- Faulted request: `misaligned` pulses in N+1; the next request can be accepted in N+1.
- Load following a store to the same word: correct, because the write commits before the read edge.

## Structure
- `lsu_pkg` contains:
  - the state enum (`IDLE`, `LOAD_RESP`, `RMW_MERGE`);
  - `funct3` localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the function `isMisaligned(funct3, addr[1:0], write)`.
- Sub-module `lsu_lane_align`, purely combinational:
  - extract-and-extend path: (word, offset, `funct3`) → 32-bit result;
  - merge path: (word, offset, size, data) → merged word.
- The top level holds only the FSM, the latches and the strobe decode.

## Test plan
- Preload word 0x100 = 0x8899AABB. Run lb @0x103, lbu @0x103, lh @0x102, lhu @0x102 → `respData` 0xFFFFFF88, 0x00000088, 0xFFFF8899, 0x00008899, each in N+2 with one `stall` cycle.
- sb 0x5A @0x101 on word 0x11223344 → `stall` for 1 cycle, single `memWrite` in N+1, memory = 0x11225A44. Then sh 0xBEEF @0x102 → 0xBEEF5A44.
- Back-to-back sw every cycle to 0x0, 0x4, 0x8 → no stall, 3 consecutive `memWrite` cycles, then lw from each address returns the data written.
- lw @0x102, sh @0x001, `funct3`=011 → `misaligned` pulse each in N+1; `memRead`/`memWrite` stay 0; memory unchanged.
- Assert `rst` during `RMW_MERGE` of sb 0xFF @0x200 → no write occurs, word unchanged; all outputs 0; next lw accepted normally.
- sw 0xCAFEF00D @0x40, then lw @0x40 in the next cycle → `respData`=0xCAFEF00D.
